reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 19 +
 rtl/reset_btn_filter.sv | 62 ++++++
 rtl/reset_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
//   state_e      : sequencer states
//   Cause*Idx    : bit positions inside rst_cause_o ({lock_loss, button, software})
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    HOLD      = 3'd2,
    BTN_HELD  = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam int unsigned CauseW       = 3;
  localparam int unsigned CauseLockIdx = 2;
  localparam int unsigned CauseBtnIdx  = 1;
  localparam int unsigned CauseSwIdx   = 0;

endpackage

// File: rtl/reset_btn_filter.sv
// Reset push-button conditioning: synchronises the raw active-low button
// into clk_i and debounces it.
//   clk_i         : clock
//   rst_ni        : async active-low reset (button treated as released)
//   btn_ni        : raw active-low button, asynchronous and bouncy
//   btn_pressed_o : debounced, active-high "button is pressed"
module reset_btn_filter #(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 500
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic btn_pressed_o
);

  localparam int unsigned       CntW   = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0]   DbLast = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  btn_s;
  logic                  db_q, db_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  // Synchroniser resets to 1 so a reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], btn_ni};
    end
  end

  assign btn_s = sync_q[SyncStages-1];

  // The debounced level flips on the DebounceCycles-th consecutive cycle in
  // which the synchronised input disagrees with it; agreement clears the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (btn_s != db_q) begin
      if (cnt_q == DbLast) begin
        db_d = btn_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign btn_pressed_o = ~db_q;

endmodule

// File: rtl/reset_sequencer.sv
// System reset sequencer: waits for a settled PLL lock, holds the system in
// reset for a fixed time, then releases it. Re-enters reset on lock loss,
// a debounced button press or a software request, and records the cause.
//   clk_i        : clock
//   rst_ni       : async active-low reset
//   pll_locked_i : PLL lock, asynchronous
//   btn_ni       : raw reset button, active-low, asynchronous
//   sw_rst_req_i : one-cycle synchronous software reset request
//   rst_sys_no   : registered system reset, active-low
//   rst_done_o   : high while in RUN
//   rst_cause_o  : sticky {lock_loss, button, software}; 000 = power-on
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned SyncStages       = 2,
  parameter int unsigned LockSettleCycles = 16,
  parameter int unsigned HoldCycles       = 195,
  parameter int unsigned DebounceCycles   = 500
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pll_locked_i,
  input  logic              btn_ni,
  input  logic              sw_rst_req_i,
  output logic              rst_sys_no,
  output logic              rst_done_o,
  output logic [CauseW-1:0] rst_cause_o
);

  localparam int unsigned        SettleW    = $clog2(LockSettleCycles + 1);
  localparam int unsigned        HoldW      = $clog2(HoldCycles + 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(LockSettleCycles - 1);
  localparam logic [SettleW-1:0] SettleMax  = SettleW'(LockSettleCycles);
  localparam logic [HoldW-1:0]   HoldLast   = HoldW'(HoldCycles - 1);
  localparam logic [HoldW-1:0]   HoldMax    = HoldW'(HoldCycles);

  logic [SyncStages-1:0] lock_sync_q;
  logic                  lock_s;
  logic                  btn_pressed;

  state_e              state_q, state_d;
  logic [SettleW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CauseW-1:0]   cause_q, cause_d;
  logic                rst_sys_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SyncStages-2:0], pll_locked_i};
    end
  end

  assign lock_s = lock_sync_q[SyncStages-1];

  reset_btn_filter #(
    .SyncStages     (SyncStages),
    .DebounceCycles (DebounceCycles)
  ) u_btn_filter (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .btn_ni        (btn_ni),
    .btn_pressed_o (btn_pressed)
  );

  // Counters are zero outside their own state, so every entry into SETTLE or
  // HOLD starts a full count. Lock loss outranks everything in every state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a variable unassigned (no latches).
    state_d      = state_q;
    settle_cnt_d = '0;
    hold_cnt_d   = '0;
    cause_d      = cause_q;

    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) state_d = SETTLE;
      end

      SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (settle_cnt_q == SettleLast) begin
          state_d = HOLD;
        end else begin
          settle_cnt_d = (settle_cnt_q < SettleMax) ? settle_cnt_q + 1'b1 : settle_cnt_q;
        end
      end

      HOLD: begin
        // Software requests are deliberately not looked at here.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (btn_pressed) begin
          state_d = BTN_HELD;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = (hold_cnt_q < HoldMax) ? hold_cnt_q + 1'b1 : hold_cnt_q;
        end
      end

      BTN_HELD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (!btn_pressed) begin
          state_d = HOLD;
        end
      end

      RUN: begin
        // Only the highest-priority event is recorded as the cause.
        if (!lock_s) begin
          state_d               = WAIT_LOCK;
          cause_d               = '0;
          cause_d[CauseLockIdx] = 1'b1;
        end else if (btn_pressed) begin
          state_d              = BTN_HELD;
          cause_d              = '0;
          cause_d[CauseBtnIdx] = 1'b1;
        end else if (sw_rst_req_i) begin
          state_d             = HOLD;
          cause_d             = '0;
          cause_d[CauseSwIdx] = 1'b1;
        end
      end

      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= WAIT_LOCK;
      settle_cnt_q <= '0;
      hold_cnt_q   <= '0;
      cause_q      <= '0;
      rst_sys_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      cause_q      <= cause_d;
      // Registered from the current state only: releases one cycle after
      // RUN is entered and never depends combinationally on an input.
      rst_sys_q    <= (state_q == RUN);
    end
  end

  assign rst_sys_no  = rst_sys_q;
  assign rst_done_o  = (state_q == RUN);
  assign rst_cause_o = cause_q;

endmodule
